// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
// serial_link_pkg : shared constants and TX state encoding for the serial link
// Revision 1.0
// ============================================================================
package serial_link_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 24;
  localparam int DEFAULT_MAX_OUTSTANDING = 16;

  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/serial_link_rx_collector.sv
`default_nettype none
// ============================================================================
// serial_link_rx_collector : MSB-first bit collector, presents one word at a time
// Revision 1.0
// ============================================================================
module serial_link_rx_collector
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_ser_din,
  input  logic                  i_ser_din_valid,
  output logic                  o_ser_ready,
  output logic [DATA_WIDTH-1:0] ov_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_word_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_collect;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  w_bit_fire;
  logic                  w_take;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_word;

  // Bits are refused while a finished word waits, so fire and take never overlap.
  assign w_bit_fire  = i_en & i_ser_din_valid & ~r_rx_valid;
  assign w_take      = i_en & r_rx_valid & i_rx_ready;
  assign w_last      = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_word      = {r_collect[DATA_WIDTH-2:0], i_ser_din};
  assign o_word_done = w_bit_fire & w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt  <= '0;
      r_collect  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_bit_fire) begin
      r_collect <= w_word;
      if (w_last) begin
        r_bit_cnt  <= '0;
        r_rx_data  <= w_word;
        r_rx_valid <= 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end else if (w_take) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign o_ser_ready = ~r_rx_valid;
  assign ov_rx_data  = r_rx_data;
  assign o_rx_valid  = r_rx_valid;

endmodule
`default_nettype wire

// File: rtl/serial_link_host.sv
`default_nettype none
// ============================================================================
// serial_link_host : word-to-serial TX, serial-to-word RX, in-flight word tracking
// Revision 1.0
// ============================================================================
module serial_link_host
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_en,
  input  logic [DATA_WIDTH-1:0]                  iv_tx_data,
  input  logic                                   i_tx_valid,
  output logic                                   o_tx_ready,
  output logic                                   o_ser_dout,
  output logic                                   o_ser_dout_valid,
  input  logic                                   i_ser_ready,
  input  logic                                   i_ser_din,
  input  logic                                   i_ser_din_valid,
  output logic                                   o_ser_ready,
  output logic [DATA_WIDTH-1:0]                  ov_rx_data,
  output logic                                   o_rx_valid,
  input  logic                                   i_rx_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   ov_outstanding,
  output logic                                   o_err_underflow
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  tx_state_e             r_state;
  tx_state_e             w_state_next;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [CNT_W-1:0]      r_tx_cnt;
  logic [OUT_W-1:0]      r_outstanding;
  logic                  r_err;
  logic                  w_tx_fire;
  logic                  w_bit_fire;
  logic                  w_tx_done;
  logic                  w_rx_done;

  assign o_tx_ready       = (r_state == TX_IDLE) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign o_ser_dout_valid = (r_state == TX_SHIFT);
  assign o_ser_dout       = r_tx_shift[DATA_WIDTH-1];

  assign w_tx_fire  = i_en & i_tx_valid & o_tx_ready;
  assign w_bit_fire = i_en & i_ser_ready & o_ser_dout_valid;
  assign w_tx_done  = w_bit_fire & (r_tx_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TX_IDLE:  if (w_tx_fire) w_state_next = TX_SHIFT;
      TX_SHIFT: if (w_tx_done) w_state_next = TX_IDLE;
      default:  w_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
    end else if (w_tx_fire) begin
      r_tx_shift <= iv_tx_data;
      r_tx_cnt   <= CNT_W'(DATA_WIDTH - 1);
    end else if (w_bit_fire) begin
      r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      r_tx_cnt   <= r_tx_cnt - 1'b1;
    end
  end

  // A return with nothing in flight is flagged but never drives the count below zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_tx_done && !w_rx_done) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (w_rx_done && !w_tx_done && (r_outstanding != '0)) begin
        r_outstanding <= r_outstanding - 1'b1;
      end
      if (w_rx_done && (r_outstanding == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ov_outstanding  = r_outstanding;
  assign o_err_underflow = r_err;

  serial_link_rx_collector #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_en            (i_en),
    .i_ser_din       (i_ser_din),
    .i_ser_din_valid (i_ser_din_valid),
    .o_ser_ready     (o_ser_ready),
    .ov_rx_data      (ov_rx_data),
    .o_rx_valid      (o_rx_valid),
    .i_rx_ready      (i_rx_ready),
    .o_word_done     (w_rx_done)
  );

endmodule
`default_nettype wire
